// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with valid/ready handshake, 2-entry skid buffer and sync flush.
// Optional back-pressure counter on stall_cnt when PIPE_STALL_CNT_EN is defined.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W = 54,
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
`ifdef PIPE_STALL_CNT_EN
    output logic [CNT_W-1:0]  stall_cnt,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_xfer;
    logic              out_xfer;

    // in_ready is a pure state decode so it never depends on out_ready.
    assign in_ready  = !rst && (state_q != StFull);
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_data_q;
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign in_xfer   = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d     = StOne;
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end
            end
            StOne: begin
                if (in_xfer && out_xfer) begin
                    main_data_d = in_data;
                    main_ctrl_d = in_ctrl;
                end else if (in_xfer) begin
                    state_d     = StFull;
                    skid_data_d = in_data;
                    skid_ctrl_d = in_ctrl;
                end else if (out_xfer) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (out_xfer) begin
                    state_d     = StOne;
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        // Flush drops everything, but payload registers keep their contents so out_data holds.
        if (flush) begin
            state_d     = StEmpty;
            main_data_d = main_data_q;
            main_ctrl_d = main_ctrl_q;
            skid_data_d = skid_data_q;
            skid_ctrl_d = skid_ctrl_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed self-checking bench for pipe_stage_elastic (stall counter checked when
// PIPE_STALL_CNT_EN is defined).
module tb_pipe_stage_elastic;

    localparam int unsigned DATA_W = 54;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(
        .DATA_W(DATA_W),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_ctrl  (in_ctrl),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ctrl (out_ctrl)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [63:0] d,
                             input logic [63:0] c, input logic r);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".data"},  64'(out_data),  d);
        check({tag, ".ctrl"},  64'(out_ctrl),  c);
        check({tag, ".ready"}, 64'(in_ready),  64'(r));
    endtask

    initial begin
        #3;
        check_out("reset", 1'b0, 64'h0, 64'h0, 1'b0);
        step();
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(in_ready), 64'h1);

        // Pass-through at full rate
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 3'b101; in_data = 54'd1;
        step(); check_out("pass1", 1'b1, 64'd1, 64'd5, 1'b1); in_data = 54'd2;
        step(); check_out("pass2", 1'b1, 64'd2, 64'd5, 1'b1); in_data = 54'd3;
        step(); check_out("pass3", 1'b1, 64'd3, 64'd5, 1'b1);

        // Bubble: control forced to zero, data held
        in_valid = 1'b0; in_ctrl = 3'b111; in_data = 54'h3f;
        step(); check_out("bubble1", 1'b0, 64'd3, 64'd0, 1'b1);
        step(); check_out("bubble2", 1'b0, 64'd3, 64'd0, 1'b1);

        // Back-pressure fills the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 54'hA; in_ctrl = 3'd1;
        step(); check_out("skid_a", 1'b1, 64'hA, 64'd1, 1'b1);
        in_data = 54'hB; in_ctrl = 3'd2;
        step(); check_out("skid_full", 1'b1, 64'hA, 64'd1, 1'b0);
        in_data = 54'hC; in_ctrl = 3'd3;
        step(); check_out("skid_hold", 1'b1, 64'hA, 64'd1, 1'b0);
        out_ready = 1'b1;
        step(); check_out("drain_b", 1'b1, 64'hB, 64'd2, 1'b1);
        in_valid = 1'b0;
        step(); check_out("drain_empty", 1'b0, 64'hB, 64'd0, 1'b1);

        // Flush while FULL, with an input beat offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = 54'h10; in_ctrl = 3'd6;
        step(); in_data = 54'h11;
        step(); check("flush_pre_full", 64'(in_ready), 64'h0);
        flush = 1'b1; in_data = 54'h12;
        step(); flush = 1'b0; in_valid = 1'b0;
        check_out("flush_full", 1'b0, 64'h10, 64'd0, 1'b1);
        out_ready = 1'b1;
        step(); check_out("flush_full2", 1'b0, 64'h10, 64'd0, 1'b1);

        // Flush in ONE drops the same-cycle accepted beat
        out_ready = 1'b0; in_valid = 1'b1; in_data = 54'h20; in_ctrl = 3'd4;
        step(); check_out("one_pre", 1'b1, 64'h20, 64'd4, 1'b1);
        flush = 1'b1; in_data = 54'h21;
        step(); flush = 1'b0; in_valid = 1'b0;
        check_out("flush_one", 1'b0, 64'h20, 64'd0, 1'b1);

        // Asynchronous reset between edges while in ONE
        in_valid = 1'b1; in_data = 54'h33; in_ctrl = 3'd3;
        step(); check_out("pre_rst", 1'b1, 64'h33, 64'd3, 1'b1);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 check_out("async_rst", 1'b0, 64'h0, 64'h0, 1'b0);
        step(); check("rst_held_ready", 64'(in_ready), 64'h0);
        rst = 1'b0;
        step(); check_out("post_rst", 1'b0, 64'h0, 64'h0, 1'b1);

`ifdef PIPE_STALL_CNT_EN
        check("stall_zero", 64'(stall_cnt), 64'h0);
        out_ready = 1'b0; in_valid = 1'b1; in_data = 54'h44; in_ctrl = 3'd1;
        step(); in_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("stall_sat", 64'(stall_cnt), 64'd15);
        flush = 1'b1;
        step(); flush = 1'b0;
        step(); check("stall_flush", 64'(stall_cnt), 64'd15);
        rst = 1'b1;
        #1 check("stall_rst", 64'(stall_cnt), 64'h0);
        step(); rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
